// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes, FSM state type and window/tap to pixel index mapping.
package conv_pkg;
  localparam int DW_DEF = 8;
  localparam int IMG_DEF = 4;
  localparam int K_DEF = 3;
  localparam int OUT_DEF = IMG_DEF - K_DEF + 1;
  localparam int NPIX_DEF = IMG_DEF * IMG_DEF;
  localparam int NTAP_DEF = K_DEF * K_DEF;
  localparam int ACC_W = 20;
  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;
  function automatic int pix_index(input int img, input int k, input int win, input int tap);
    int out = img - k + 1;
    return (win / out + tap / k) * img + win % out + tap % k;
  endfunction
endpackage

// File: rtl/conv_tap_counter.sv
// conv_tap_counter: nested tap/window counter with look-ahead next values and flags.
module conv_tap_counter #(
  parameter int NTAP = 9,
  parameter int NWIN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [3:0] tap,
  output logic [1:0] win,
  output logic [3:0] tap_nxt,
  output logic [1:0] win_nxt,
  output logic       first_nxt,
  output logic       last_nxt,
  output logic       wrap
);
  logic last;
  assign last = tap == 4'(NTAP - 1);
  assign wrap = last && win == 2'(NWIN - 1);
  assign tap_nxt = clr ? '0 : adv ? (last ? '0 : tap + 4'd1) : tap;
  assign win_nxt = clr ? '0 : (adv && last) ? win + 2'd1 : win;
  assign first_nxt = tap_nxt == '0;
  assign last_nxt = tap_nxt == 4'(NTAP - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap <= '0;
      win <= '0;
    end else begin
      tap <= tap_nxt;
      win <= win_nxt;
    end
  end
endmodule

// File: rtl/conv_window_reader.sv
// conv_window_reader: snapshots image/filter banks on start and streams (pixel, weight) pairs per window.
// Optional per-window accumulator enabled by CONV_WINDOW_READER_ACC_EN.
module conv_window_reader
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IMG = IMG_DEF,
  parameter int K = K_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IMG*IMG*DW-1:0] in_flat,
  input  logic [K*K*DW-1:0]     flt_flat,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         pix_data,
  output logic [DW-1:0]         wgt_data,
  output logic [3:0]            tap_idx,
  output logic [1:0]            win_idx,
  output logic                  first,
  output logic                  last
`ifdef CONV_WINDOW_READER_ACC_EN
  ,
  output logic [ACC_W-1:0]      acc_out,
  output logic                  acc_valid,
  output logic [1:0]            acc_win
`endif
);
  localparam int OUT = IMG - K + 1;
  localparam int NPIX = IMG * IMG;
  localparam int NTAP = K * K;
  state_t state;
  logic [NPIX*DW-1:0] img_snap, img_src;
  logic [NTAP*DW-1:0] flt_snap, flt_src;
  logic [3:0] tap_nxt;
  logic [1:0] win_nxt;
  logic first_nxt, last_nxt, wrap, take, xfer, load;
  logic [DW-1:0] pix_nxt, wgt_nxt;
  assign take = state == IDLE && start;
  assign xfer = out_valid && out_ready;
  assign load = take || (xfer && !wrap);
  // On start the bank is read directly so the first pair is ready one cycle later
  assign img_src = take ? in_flat : img_snap;
  assign flt_src = take ? flt_flat : flt_snap;
  assign pix_nxt = img_src[DW*pix_index(IMG, K, int'(win_nxt), int'(tap_nxt)) +: DW];
  assign wgt_nxt = flt_src[DW*int'(tap_nxt) +: DW];
  conv_tap_counter #(.NTAP(NTAP), .NWIN(OUT*OUT)) u_cnt (
    .clk(clk), .rst(rst), .clr(take), .adv(xfer),
    .tap(tap_idx), .win(win_idx), .tap_nxt(tap_nxt), .win_nxt(win_nxt),
    .first_nxt(first_nxt), .last_nxt(last_nxt), .wrap(wrap)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      out_valid <= 1'b0;
      first <= 1'b0;
      last <= 1'b0;
      pix_data <= '0;
      wgt_data <= '0;
      img_snap <= '0;
      flt_snap <= '0;
    end else begin
      if (load) begin
        pix_data <= pix_nxt;
        wgt_data <= wgt_nxt;
        first <= first_nxt;
        last <= last_nxt;
      end else if (xfer) begin
        pix_data <= '0;
        wgt_data <= '0;
        first <= 1'b0;
        last <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          img_snap <= in_flat;
          flt_snap <= flt_flat;
          state <= STREAM;
          busy <= 1'b1;
          out_valid <= 1'b1;
        end
        STREAM: if (xfer && wrap) begin
          state <= FIN;
          out_valid <= 1'b0;
          done <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONV_WINDOW_READER_ACC_EN
  logic [ACC_W-1:0] acc, acc_sum;
  logic [2*DW-1:0] prod;
  assign prod = pix_data * wgt_data;
  assign acc_sum = (first ? '0 : acc) + ACC_W'(prod);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      acc_out <= '0;
      acc_valid <= 1'b0;
      acc_win <= '0;
    end else begin
      acc_valid <= xfer && last;
      if (xfer) acc <= acc_sum;
      if (xfer && last) begin
        acc_out <= acc_sum;
        acc_win <= win_idx;
      end
    end
  end
`endif
endmodule

// File: tb/tb_conv_window_reader.sv
// tb_conv_window_reader: randomized scoreboard bench with a window-level reference model.
module tb_conv_window_reader;
  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] wgt;
    logic [3:0] tap;
    logic [1:0] win;
    logic       first;
    logic       last;
  } pair_t;
  logic clk, rst, start, out_ready;
  logic [127:0] in_flat;
  logic [71:0] flt_flat;
  logic busy, done, out_valid, first, last;
  logic [7:0] pix_data, wgt_data;
  logic [3:0] tap_idx;
  logic [1:0] win_idx;
`ifdef CONV_WINDOW_READER_ACC_EN
  logic [19:0] acc_out;
  logic acc_valid;
  logic [1:0] acc_win;
  logic [21:0] acc_q[$];
  int last_tail_cyc = -10;
`endif
  pair_t exp_q[$];
  pair_t cur, prev;
  bit prev_hold, rnd_ready;
  int compared = 0, mismatched = 0, cyc = 0, done_cnt = 0, xfer_tot = 0, last_xfer_cyc = -10;
  int img[16], flt[9];

  conv_window_reader dut (
    .clk(clk), .rst(rst), .in_flat(in_flat), .flt_flat(flt_flat), .start(start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .pix_data(pix_data), .wgt_data(wgt_data), .tap_idx(tap_idx), .win_idx(win_idx),
    .first(first), .last(last)
`ifdef CONV_WINDOW_READER_ACC_EN
    , .acc_out(acc_out), .acc_valid(acc_valid), .acc_win(acc_win)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur = '{pix: pix_data, wgt: wgt_data, tap: tap_idx, win: win_idx, first: first, last: last};

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string n);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected event (cycle %0d)", n, cyc);
  endtask

  function automatic logic [63:0] all_outs();
`ifdef CONV_WINDOW_READER_ACC_EN
    return 64'({busy, done, out_valid, first, last, pix_data, wgt_data, tap_idx, win_idx,
                acc_out, acc_valid, acc_win});
`else
    return 64'({busy, done, out_valid, first, last, pix_data, wgt_data, tap_idx, win_idx});
`endif
  endfunction

  // Reference: each window is the K x K sub-image at (row, col) = (w / 2, w % 2)
  task automatic push_model();
    for (int w = 0; w < 4; w++) begin
      int sum = 0;
      for (int t = 0; t < 9; t++) begin
        int p = img[(w / 2 + t / 3) * 4 + (w % 2) + (t % 3)];
        exp_q.push_back('{pix: 8'(p), wgt: 8'(flt[t]), tap: 4'(t), win: 2'(w),
                          first: 1'(t == 0), last: 1'(t == 8)});
        sum += p * flt[t];
      end
`ifdef CONV_WINDOW_READER_ACC_EN
      acc_q.push_back({2'(w), 20'(sum)});
`endif
    end
  endtask

  task automatic load_bank();
    for (int i = 0; i < 16; i++) in_flat[8*i +: 8] = 8'(img[i]);
    for (int i = 0; i < 9; i++) flt_flat[8*i +: 8] = 8'(flt[i]);
  endtask

  task automatic randomize_bank();
    for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++) flt[i] = int'($urandom_range(0, 255));
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfer_tot < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("xfer_reached", 64'(xfer_tot >= target), 64'(1));
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 64'(done_cnt), 64'(base + 1));
  endtask

  task automatic begin_stream();
    load_bank();
    push_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_pair_valid", 64'({out_valid, busy, tap_idx, win_idx, first, last}),
          64'({1'b1, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0}));
  endtask

  task automatic run_stream();
    int b = done_cnt;
    begin_stream();
    wait_done(b);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) check("hold_stable", 64'(cur), 64'(prev));
      if (out_valid) check("busy_with_valid", 64'(busy), 64'(1));
`ifdef CONV_WINDOW_READER_ACC_EN
      if (acc_valid) begin
        check("acc_latency", 64'(cyc), 64'(last_tail_cyc + 1));
        if (acc_q.size() == 0) fail_now("acc_extra_pulse");
        else check("acc_value", 64'({acc_win, acc_out}), 64'(acc_q.pop_front()));
      end
      if (done) check("acc_pulses_all_seen", 64'(acc_q.size()), 64'(0));
`endif
      if (done) begin
        check("done_latency", 64'(cyc), 64'(last_xfer_cyc + 1));
        check("done_all_pairs", 64'(exp_q.size()), 64'(0));
        done_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("extra_transfer");
        else check("pair", 64'(cur), 64'(exp_q.pop_front()));
        xfer_tot++;
        last_xfer_cyc = cyc;
`ifdef CONV_WINDOW_READER_ACC_EN
        if (last) last_tail_cyc = cyc;
`endif
      end
      prev_hold = out_valid && !out_ready;
      prev = cur;
    end
  end

  initial begin
    int b, d;
    rst = 1'b1;
    start = 1'b0;
    in_flat = '0;
    flt_flat = '0;
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", all_outs(), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("idle_outputs", all_outs(), 64'(0));
    end
    img = '{152, 249, 170, 35, 210, 182, 74, 192, 65, 161, 116, 62, 235, 203, 182, 21};
    flt = '{181, 173, 216, 20, 191, 90, 2, 181, 24};
    run_stream();
    rnd_ready = 1'b1;
    run_stream();
    // Bank changes and a second start mid-stream must not disturb the snapshot
    randomize_bank();
    b = xfer_tot;
    d = done_cnt;
    begin_stream();
    wait_xfers(b + 10);
    in_flat = {$urandom, $urandom, $urandom, $urandom};
    flt_flat = {8'($urandom), $urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d);
    repeat (60) @(posedge clk);
    #1;
    check("single_done", 64'(done_cnt), 64'(d + 1));
    // Reset right after the 17th transfer abandons the stream silently
    randomize_bank();
    b = xfer_tot;
    d = done_cnt;
    begin_stream();
    wait_xfers(b + 17);
    rst = 1'b1;
    #1;
    check("midstream_reset_outputs", all_outs(), 64'(0));
    exp_q.delete();
`ifdef CONV_WINDOW_READER_ACC_EN
    acc_q.delete();
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt), 64'(d));
    run_stream();
    repeat (3) begin
      randomize_bank();
      run_stream();
    end
    rnd_ready = 1'b0;
    randomize_bank();
    run_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
